gf16_masked_mul_out_stage: RTL and testbench

- Consumer end of the 2-share masked GF(16) inversion stage in the two-cycle Canright-style AES S-box datapath.
- Takes the shared 4-bit GF(16) inverse d and the original 8-bit shared S-box input, held in an internal delay line.
- Computes the two first-order DOM-masked GF(16) products that form the shared 8-bit GF(256) inverse.
- Checks that the inverse arrives exactly DELAY cycles after its input. Output feeds the affine/basis-change stage.

---
 rtl/gf16_masked_mul_out_stage_if.sv | 24 ++
 rtl/gf16_masked_mul_out_stage.sv | 138 +++++++++++++
 tb/tb_gf16_masked_mul_out_stage.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/gf16_masked_mul_out_stage_if.sv
// Bus bundle for the masked GF(16) output-multiply stage: input shares in, output shares out.
interface gf16_masked_mul_out_stage_if;
    logic       x_valid;
    logic [7:0] x_s0;
    logic [7:0] x_s1;
    logic       d_valid;
    logic [3:0] d_s0;
    logic [3:0] d_s1;
    logic [7:0] ran;
    logic       out_valid;
    logic [7:0] out_s0;
    logic [7:0] out_s1;
    logic       seq_err;

    modport master (
        output x_valid, x_s0, x_s1, d_valid, d_s0, d_s1, ran,
        input  out_valid, out_s0, out_s1, seq_err
    );

    modport slave (
        input  x_valid, x_s0, x_s1, d_valid, d_s0, d_s1, ran,
        output out_valid, out_s0, out_s1, seq_err
    );
endinterface

// File: rtl/gf16_masked_mul_out_stage.sv
// Consumer end of the masked GF(16) inversion: multiplies the shared GF(16) inverse by the
// delayed S-box input nibbles with two DOM-masked products, giving the shared GF(256) inverse.
module gf16_masked_mul_out_stage #(
    parameter int unsigned DELAY = 2
) (
    input logic                         clk,
    input logic                         rst,
    gf16_masked_mul_out_stage_if.slave  bus
);

    localparam int unsigned LAST = DELAY - 1;

    // Polynomial-basis multiply modulo x^4 + x + 1.
    function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] acc;
        logic [3:0] sh;
        acc = 4'h0;
        sh  = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[2:0], 1'b0} ^ (sh[3] ? 4'h3 : 4'h0);
        end
        return acc;
    endfunction

    // Delay line: shares kept in separate registers, never combined.
    logic [DELAY-1:0] dl_valid;
    logic [7:0]       dl_s0 [DELAY];
    logic [7:0]       dl_s1 [DELAY];

    logic       xd_valid;
    logic [7:0] xd_s0;
    logic [7:0] xd_s1;

    assign xd_valid = dl_valid[LAST];
    assign xd_s0    = dl_s0[LAST];
    assign xd_s1    = dl_s1[LAST];

    // Shift the valid bits of the delay line every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            dl_valid <= '0;
        end else begin
            dl_valid[0] <= bus.x_valid;
            for (int i = 1; i < int'(DELAY); i++) dl_valid[i] <= dl_valid[i-1];
        end
    end

    // Shift the share data of the delay line every cycle; no reset needed.
    always_ff @(posedge clk) begin
        dl_s0[0] <= bus.x_s0;
        dl_s1[0] <= bus.x_s1;
        for (int i = 1; i < int'(DELAY); i++) begin
            dl_s0[i] <= dl_s0[i-1];
            dl_s1[i] <= dl_s1[i-1];
        end
    end

    // Stage 1: cross-domain products, refreshed with ran before they are ever combined.
    logic [3:0] p00_hi_d, p01_hi_d, p10_hi_d, p11_hi_d;
    logic [3:0] p00_lo_d, p01_lo_d, p10_lo_d, p11_lo_d;
    logic [3:0] p00_hi_q, p01_hi_q, p10_hi_q, p11_hi_q;
    logic [3:0] p00_lo_q, p01_lo_q, p10_lo_q, p11_lo_q;
    logic       s1_valid_q;

    // Compute the four partial products of each nibble product.
    always_comb begin
        // Hi output nibble uses the lo input nibble and ran[7:4].
        p00_hi_d = gf16_mul(bus.d_s0, xd_s0[3:0]);
        p01_hi_d = gf16_mul(bus.d_s0, xd_s1[3:0]) ^ bus.ran[7:4];
        p10_hi_d = gf16_mul(bus.d_s1, xd_s0[3:0]) ^ bus.ran[7:4];
        p11_hi_d = gf16_mul(bus.d_s1, xd_s1[3:0]);
        // Lo output nibble uses the hi input nibble and ran[3:0].
        p00_lo_d = gf16_mul(bus.d_s0, xd_s0[7:4]);
        p01_lo_d = gf16_mul(bus.d_s0, xd_s1[7:4]) ^ bus.ran[3:0];
        p10_lo_d = gf16_mul(bus.d_s1, xd_s0[7:4]) ^ bus.ran[3:0];
        p11_lo_d = gf16_mul(bus.d_s1, xd_s1[7:4]);
    end

    // Stage-1 valid; data registers load only on d_valid.
    always_ff @(posedge clk) begin
        if (rst) s1_valid_q <= 1'b0;
        else     s1_valid_q <= bus.d_valid;
    end

    // Stage-1 product registers.
    always_ff @(posedge clk) begin
        if (bus.d_valid) begin
            p00_hi_q <= p00_hi_d;
            p01_hi_q <= p01_hi_d;
            p10_hi_q <= p10_hi_d;
            p11_hi_q <= p11_hi_d;
            p00_lo_q <= p00_lo_d;
            p01_lo_q <= p01_lo_d;
            p10_lo_q <= p10_lo_d;
            p11_lo_q <= p11_lo_d;
        end
    end

    // Stage 2: fold each share's pair of registered products.
    logic [7:0] out_s0_d, out_s1_d;
    logic [7:0] out_s0_q, out_s1_q;
    logic       out_valid_q;

    // Share 0 from p00/p01, share 1 from p11/p10.
    always_comb begin
        out_s0_d = {p00_hi_q ^ p01_hi_q, p00_lo_q ^ p01_lo_q};
        out_s1_d = {p11_hi_q ^ p10_hi_q, p11_lo_q ^ p10_lo_q};
    end

    // Output registers hold while no stage-1 result is arriving.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_s0_q    <= 8'h00;
            out_s1_q    <= 8'h00;
        end else begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_s0_q <= out_s0_d;
                out_s1_q <= out_s1_d;
            end
        end
    end

    // Sticky flag for any cycle where the inverse and the delayed input disagree on validity.
    logic seq_err_q;
    always_ff @(posedge clk) begin
        if (rst)                          seq_err_q <= 1'b0;
        else if (bus.d_valid != xd_valid) seq_err_q <= 1'b1;
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_s0    = out_s0_q;
    assign bus.out_s1    = out_s1_q;
    assign bus.seq_err   = seq_err_q;

endmodule

// File: tb/tb_gf16_masked_mul_out_stage.sv
// Self-checking bench for gf16_masked_mul_out_stage with DELAY = 2.
module tb_gf16_masked_mul_out_stage;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    gf16_masked_mul_out_stage_if bus ();

    gf16_masked_mul_out_stage #(
        .DELAY(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] x_s0;
        logic [7:0] x_s1;
        logic [3:0] d_s0;
        logic [3:0] d_s1;
        logic [7:0] ran;
        logic [7:0] expect_out;
    } vec_t;

    vec_t vecs [7];

    // Reference multiply: carry-less product, then long division by x^4 + x + 1.
    function automatic logic [3:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
        logic [6:0] prod;
        prod = 7'h0;
        for (int i = 0; i < 4; i++)
            if (b[i]) prod = prod ^ (7'(a) << i);
        for (int k = 6; k >= 4; k--)
            if (prod[k]) prod = prod ^ (7'h13 << (k - 4));
        return prod[3:0];
    endfunction

    function automatic logic [7:0] ref_out(input logic [7:0] x, input logic [3:0] d);
        return {ref_mul(d, x[3:0]), ref_mul(d, x[7:4])};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.x_valid = 1'b0;
        bus.x_s0    = 8'h00;
        bus.x_s1    = 8'h00;
        bus.d_valid = 1'b0;
        bus.d_s0    = 4'h0;
        bus.d_s1    = 4'h0;
        bus.ran     = 8'h00;
    endtask

    // Leaves the bench at the first cycle after rst deasserts.
    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    logic [7:0] rx [64];
    logic [3:0] rd [64];

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;
        idle_inputs();
        #1;

        vecs[0] = '{"plain_x32_d9",  8'h32, 8'h00, 4'h9, 4'h0, 8'h00, 8'h18};
        vecs[1] = '{"masked_x32_d9", 8'hA7, 8'h95, 4'h5, 4'hC, 8'h6B, 8'h18};
        vecs[2] = '{"d0_xff",        8'h3C, 8'hC3, 4'h7, 4'h7, 8'hA5, 8'h00};
        vecs[3] = '{"d1_x5c",        8'hE1, 8'hBD, 4'h4, 4'h5, 8'h3F, 8'hC5};
        vecs[4] = '{"d2_x01",        8'h01, 8'h00, 4'h2, 4'h0, 8'h00, 8'h20};
        vecs[5] = '{"d2_x80_reduce", 8'hF0, 8'h70, 4'hB, 4'h9, 8'hC4, 8'h03};
        vecs[6] = '{"df_x22",        8'h22, 8'h00, 4'hF, 4'h0, 8'h00, 8'hDD};

        // Reset state.
        do_reset();
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_out_s0",    32'(bus.out_s0),    32'h0);
        check("rst_out_s1",    32'(bus.out_s1),    32'h0);
        check("rst_seq_err",   32'(bus.seq_err),   32'h0);

        // Table vectors: x at t0, d at t2, result at t4.
        for (int v = 0; v < 7; v++) begin
            bus.x_valid = 1'b1;
            bus.x_s0    = vecs[v].x_s0;
            bus.x_s1    = vecs[v].x_s1;
            step();
            bus.x_valid = 1'b0;
            step();
            bus.d_valid = 1'b1;
            bus.d_s0    = vecs[v].d_s0;
            bus.d_s1    = vecs[v].d_s1;
            bus.ran     = vecs[v].ran;
            step();
            bus.d_valid = 1'b0;
            check({vecs[v].name, "_early_valid"}, 32'(bus.out_valid), 32'h0);
            step();
            check({vecs[v].name, "_valid"}, 32'(bus.out_valid), 32'h1);
            check(vecs[v].name, 32'(bus.out_s0 ^ bus.out_s1), 32'(vecs[v].expect_out));
            check({vecs[v].name, "_seq_err"}, 32'(bus.seq_err), 32'h0);
            step();
            check({vecs[v].name, "_drop"}, 32'(bus.out_valid), 32'h0);
        end

        // 64 back-to-back random transactions against the reference model.
        do_reset();
        for (int i = 0; i < 64; i++) begin
            rx[i] = 8'($urandom);
            rd[i] = 4'($urandom);
        end
        for (int c = 0; c < 70; c++) begin
            logic [7:0] m8;
            logic [3:0] m4;
            check("rand_valid", 32'(bus.out_valid), 32'((c >= 4 && c < 68) ? 1 : 0));
            if (c >= 4 && c < 68)
                check("rand_out", 32'(bus.out_s0 ^ bus.out_s1), 32'(ref_out(rx[c-4], rd[c-4])));
            m8 = 8'($urandom);
            m4 = 4'($urandom);
            bus.x_valid = (c < 64);
            bus.x_s0    = (c < 64) ? m8 : 8'h00;
            bus.x_s1    = (c < 64) ? (m8 ^ rx[c]) : 8'h00;
            bus.d_valid = (c >= 2 && c < 66);
            bus.d_s0    = (c >= 2 && c < 66) ? m4 : 4'h0;
            bus.d_s1    = (c >= 2 && c < 66) ? (m4 ^ rd[c-2]) : 4'h0;
            bus.ran     = 8'($urandom);
            step();
        end
        check("rand_seq_err", 32'(bus.seq_err), 32'h0);

        // Misaligned inverse: x at t0, d at t3.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            if (c == 4) check("misalign_seq_err_t4", 32'(bus.seq_err), 32'h1);
            idle_inputs();
            bus.x_valid = (c == 0);
            bus.x_s0    = 8'h32;
            bus.d_valid = (c == 3);
            bus.d_s0    = 4'h9;
            step();
        end
        idle_inputs();
        for (int c = 0; c < 20; c++) step();
        check("misalign_sticky", 32'(bus.seq_err), 32'h1);
        do_reset();
        check("misalign_rst_clear", 32'(bus.seq_err), 32'h0);

        // Reset mid-flight at t3; fresh transaction at t5 completes at t9.
        do_reset();
        for (int c = 0; c < 12; c++) begin
            if (c >= 4 && c <= 10) begin
                check("midrst_valid", 32'(bus.out_valid), 32'((c == 9) ? 1 : 0));
                if (c < 9) begin
                    check("midrst_s0_zero", 32'(bus.out_s0), 32'h0);
                    check("midrst_s1_zero", 32'(bus.out_s1), 32'h0);
                end
                if (c == 9) check("midrst_new_out", 32'(bus.out_s0 ^ bus.out_s1), 32'h18);
                if (c == 10) check("midrst_seq_err", 32'(bus.seq_err), 32'h0);
            end
            idle_inputs();
            rst = (c == 3);
            if (c <= 2) begin
                bus.x_valid = 1'b1;
                bus.x_s0    = 8'($urandom);
                bus.x_s1    = 8'($urandom);
            end
            if (c == 5) begin
                bus.x_valid = 1'b1;
                bus.x_s0    = 8'hA7;
                bus.x_s1    = 8'h95;
            end
            if (c == 2 || c == 3) begin
                bus.d_valid = 1'b1;
                bus.d_s0    = 4'($urandom);
                bus.d_s1    = 4'($urandom);
                bus.ran     = 8'($urandom);
            end
            if (c == 7) begin
                bus.d_valid = 1'b1;
                bus.d_s0    = 4'h5;
                bus.d_s1    = 4'hC;
                bus.ran     = 8'($urandom);
            end
            step();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
